// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes,
// register sentinel and the fetch-to-decode bundle with its bubble value.
package fetch_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } f_d_t;

    localparam f_d_t D_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'h0,
        valp:  64'h0
    };

endpackage

// File: rtl/fetch_decode.sv
// Combinational instruction splitter: fields, length, status and
// predicted next PC for the instruction at f_pc.
import fetch_stage_pkg::*;

module fetch_decode (
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output f_d_t        fd,
    output logic [63:0] pred_pc
);

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        instr_valid;
    logic        need_regids;
    logic        need_valc;
    logic [63:0] valc;
    logic [63:0] valp;

    assign icode = imem_error ? I_NOP : imem_data[7:4];
    assign ifun  = imem_error ? 4'h0  : imem_data[3:0];

    always_comb begin
        instr_valid = 1'b1;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        unique case (icode)
            I_HALT, I_NOP, I_JXX, I_CALL, I_RET: ;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
                need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            default:
                instr_valid = 1'b0;
        endcase
        // jXX and call have no register byte, so they also land here
        if (icode == I_JXX || icode == I_CALL)
            need_valc = 1'b1;
    end

    always_comb begin
        valc = 64'h0;
        if (need_valc)
            valc = need_regids ? imem_data[79:16] : imem_data[71:8];
    end

    assign valp = f_pc + 64'd1
                + {63'd0, need_regids}
                + (need_valc ? 64'd8 : 64'd0);

    always_comb begin
        fd       = D_BUBBLE;
        fd.icode = icode;
        fd.ifun  = ifun;
        fd.ra    = need_regids ? imem_data[15:12] : RNONE;
        fd.rb    = need_regids ? imem_data[11:8]  : RNONE;
        fd.valc  = valc;
        fd.valp  = valp;
        if (imem_error)
            fd.stat = S_ADR;
        else if (!instr_valid)
            fd.stat = S_INS;
        else if (icode == I_HALT)
            fd.stat = S_HLT;
        else
            fd.stat = S_AOK;
    end

    assign pred_pc = (icode == I_JXX || icode == I_CALL) ? valc : valp;

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: drives instruction memory, holds the predicted PC
// and the fetch-to-decode pipeline register with stall/bubble control.
import fetch_stage_pkg::*;

module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] f_pc,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] F_predPC,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    f_d_t        fd;
    f_d_t        d_reg;
    logic [63:0] pred_pc;
    logic [63:0] f_pred_q;

    assign imem_addr = f_pc;

    fetch_decode u_decode (
        .f_pc       (f_pc),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .fd         (fd),
        .pred_pc    (pred_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            f_pred_q <= 64'h0;
        else if (!F_stall)
            f_pred_q <= pred_pc;
    end

    // stall has priority over bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            d_reg <= D_BUBBLE;
        else if (D_stall)
            d_reg <= d_reg;
        else if (D_bubble)
            d_reg <= D_BUBBLE;
        else
            d_reg <= fd;
    end

    assign F_predPC = f_pred_q;
    assign D_stat   = d_reg.stat;
    assign D_icode  = d_reg.icode;
    assign D_ifun   = d_reg.ifun;
    assign D_rA     = d_reg.ra;
    assign D_rB     = d_reg.rb;
    assign D_valC   = d_reg.valc;
    assign D_valP   = d_reg.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] f_pc;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [63:0] F_predPC;
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .f_pc       (f_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .F_predPC   (F_predPC),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [3:0] st,
                         input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        chk({tag, ".stat"},  {60'd0, D_stat},  {60'd0, st});
        chk({tag, ".icode"}, {60'd0, D_icode}, {60'd0, ic});
        chk({tag, ".ifun"},  {60'd0, D_ifun},  {60'd0, fn});
        chk({tag, ".rA"},    {60'd0, D_rA},    {60'd0, ra});
        chk({tag, ".rB"},    {60'd0, D_rB},    {60'd0, rb});
        chk({tag, ".valC"},  D_valC, vc);
        chk({tag, ".valP"},  D_valP, vp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        f_pc       = 64'h0;
        imem_data  = 80'h0;
        imem_error = 1'b0;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        #1;
        chk("reset.predPC", F_predPC, 64'h0);
        chk_d("reset", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);

        @(negedge clk);
        reset = 1'b0;

        // irmovq $10,%rbx
        f_pc      = 64'h100;
        imem_data = 80'h0000_0000_0000_000A_F330;
        #1;
        chk("imem_addr", imem_addr, 64'h100);
        step();
        chk_d("irmovq", 4'h1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h10A);
        chk("irmovq.predPC", F_predPC, 64'h10A);

        // jmp 0x400
        @(negedge clk);
        f_pc      = 64'h200;
        imem_data = 80'h0000_0000_0000_0004_0070;
        step();
        chk_d("jmp", 4'h1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h400, 64'h209);
        chk("jmp.predPC", F_predPC, 64'h400);

        // call 0x400
        @(negedge clk);
        imem_data = 80'h0000_0000_0000_0004_0080;
        step();
        chk_d("call", 4'h1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h400, 64'h209);
        chk("call.predPC", F_predPC, 64'h400);

        // address error forces nop fields
        @(negedge clk);
        f_pc       = 64'h250;
        imem_data  = 80'h0000_0000_0000_000A_F330;
        imem_error = 1'b1;
        step();
        chk_d("adr", 4'h3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h251);
        chk("adr.predPC", F_predPC, 64'h251);

        // invalid icode
        @(negedge clk);
        imem_error = 1'b0;
        f_pc       = 64'h260;
        imem_data  = 80'h0000_0000_0000_0000_11C5;
        step();
        chk_d("ins", 4'h4, 4'hC, 4'h5, 4'hF, 4'hF, 64'h0, 64'h261);

        // halt
        @(negedge clk);
        f_pc      = 64'h300;
        imem_data = 80'h0;
        step();
        chk_d("hlt", 4'h2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301);
        chk("hlt.predPC", F_predPC, 64'h301);

        // both stalls for two edges with a new instruction presented
        @(negedge clk);
        F_stall   = 1'b1;
        D_stall   = 1'b1;
        f_pc      = 64'h500;
        imem_data = 80'h0000_0000_0000_000A_F330;
        step();
        step();
        chk_d("stall", 4'h2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301);
        chk("stall.predPC", F_predPC, 64'h301);

        // bubble alone; F register free
        @(negedge clk);
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        step();
        chk_d("bubble", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        chk("bubble.predPC", F_predPC, 64'h50A);

        // load an rrmovq, then stall+bubble together must hold it
        @(negedge clk);
        D_bubble  = 1'b0;
        f_pc      = 64'h600;
        imem_data = 80'h0000_0000_0000_0000_2120;
        step();
        chk_d("rrmovq", 4'h1, 4'h2, 4'h0, 4'h2, 4'h1, 64'h0, 64'h602);
        @(negedge clk);
        D_stall  = 1'b1;
        D_bubble = 1'b1;
        f_pc     = 64'h700;
        step();
        chk_d("stall_bub", 4'h1, 4'h2, 4'h0, 4'h2, 4'h1, 64'h0, 64'h602);
        chk("stall_bub.predPC", F_predPC, 64'h702);

        // asynchronous reset while stalled and bubbling
        #2;
        F_stall = 1'b1;
        reset   = 1'b1;
        #1;
        chk("rst_mid.predPC", F_predPC, 64'h0);
        chk_d("rst_mid", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);

        // first post-reset edge: stall still wins
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_d("post_rst", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        chk("post_rst.predPC", F_predPC, 64'h0);

        // PC wrap on nop at the top of the address space
        @(negedge clk);
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        f_pc      = 64'hFFFF_FFFF_FFFF_FFFF;
        imem_data = 80'h0000_0000_0000_0000_0010;
        step();
        chk_d("wrap", 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        chk("wrap.predPC", F_predPC, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
